// File: rtl/prng_pkg.sv
// Shared types and constants for the PRNG capture/hold path.
package prng_pkg;

  typedef enum logic {
    LIVE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam int DEB_STABLE_TICKS = 3;
  localparam int BYTE_W           = 8;

endpackage

// File: rtl/prng_capture_if.sv
// Button, random-byte and display bundle between the PRNG top and the capture stage.
interface prng_capture_if #(
  parameter int DEPTH = 4
) ();
  import prng_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  logic [BYTE_W-1:0] rand_in;
  logic              btn_capture;
  logic              btn_scroll;
  logic [6:0]        seg_lo;
  logic [6:0]        seg_hi;
  logic [CW-1:0]     count;
  logic              hold;
  logic              captured;

  modport master (
    output rand_in, btn_capture, btn_scroll,
    input  seg_lo, seg_hi, count, hold, captured
  );

  modport slave (
    input  rand_in, btn_capture, btn_scroll,
    output seg_lo, seg_hi, count, hold, captured
  );

endinterface

// File: rtl/DEC_7SEG.sv
// Hex nibble to 7-segment code, active-high, bit order {g,f,e,d,c,b,a}.
module DEC_7SEG (
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h00;
    case (hex)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      4'hF: seg = 7'h71;
      default: seg = 7'h00;
    endcase
  end

endmodule

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus tick-sampled stability filter; one press pulse per debounced rising edge.
module btn_debounce
  import prng_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic btn,
  output logic press
);

  localparam int SW = $clog2(DEB_STABLE_TICKS);

  logic          sync1_reg;
  logic          sync2_reg;
  logic          level_reg;
  logic          armed_reg;
  logic          press_reg;
  logic [SW-1:0] stable_cnt_reg;
  logic          target;

  // Until the button has been seen stably released, only a release can complete,
  // so a button held through reset never produces a press.
  assign target = armed_reg ? ~level_reg : 1'b0;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_reg      <= 1'b0;
      sync2_reg      <= 1'b0;
      level_reg      <= 1'b0;
      armed_reg      <= 1'b0;
      press_reg      <= 1'b0;
      stable_cnt_reg <= '0;
    end else begin
      sync1_reg <= btn;
      sync2_reg <= sync1_reg;
      press_reg <= 1'b0;
      if (tick) begin
        if (sync2_reg == target) begin
          if (stable_cnt_reg == SW'(DEB_STABLE_TICKS - 1)) begin
            stable_cnt_reg <= '0;
            if (!armed_reg) begin
              armed_reg <= 1'b1;
            end else begin
              level_reg <= target;
              press_reg <= target;
            end
          end else begin
            stable_cnt_reg <= stable_cnt_reg + SW'(1);
          end
        end else begin
          stable_cnt_reg <= '0;
        end
      end
    end
  end

  assign press = press_reg;

endmodule

// File: rtl/prng_capture.sv
// Captures the live random byte on a button press into a circular history and scrolls back through it.
module prng_capture
  import prng_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50_000,
  parameter int          DEPTH           = 4
) (
  input logic           clk,
  input logic           reset,
  prng_capture_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [15:0]       tick_cnt_reg;
  logic              tick;
  logic [1:0]        btn_raw;
  logic [1:0]        press;
  logic              press_cap;
  logic              press_scr;

  state_t            state_reg;
  logic [AW-1:0]     wr_ptr_reg;
  logic [AW-1:0]     age_reg;
  logic [CW-1:0]     count_reg;
  logic [BYTE_W-1:0] mem [DEPTH];
  logic [BYTE_W-1:0] disp_reg;
  logic              captured_reg;

  logic [AW-1:0]     head_idx;
  logic [AW-1:0]     cur_idx;
  logic [AW-1:0]     older_idx;
  logic              can_step_back;

  // One sample tick shared by both debouncers.
  assign tick = (tick_cnt_reg == DEBOUNCE_CYCLES - 16'd1);

  always_ff @(posedge clk) begin
    if (reset || tick) begin
      tick_cnt_reg <= '0;
    end else begin
      tick_cnt_reg <= tick_cnt_reg + 16'd1;
    end
  end

  assign btn_raw   = {bus.btn_scroll, bus.btn_capture};
  assign press_cap = press[0];
  assign press_scr = press[1];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_deb
      btn_debounce u_deb (
        .clk   (clk),
        .reset (reset),
        .tick  (tick),
        .btn   (btn_raw[gi]),
        .press (press[gi])
      );
    end
  endgenerate

  always_comb begin
    head_idx      = wr_ptr_reg - AW'(1);
    cur_idx       = head_idx - age_reg;
    older_idx     = cur_idx - AW'(1);
    can_step_back = (({1'b0, age_reg} + CW'(1)) < count_reg);
  end

  // Capture outranks scroll; disp_reg is the registered read of the history.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= LIVE;
      wr_ptr_reg   <= '0;
      age_reg      <= '0;
      count_reg    <= '0;
      disp_reg     <= '0;
      captured_reg <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      captured_reg <= 1'b0;
      if (press_cap) begin
        mem[wr_ptr_reg] <= bus.rand_in;
        wr_ptr_reg      <= wr_ptr_reg + AW'(1);
        if (count_reg != CW'(DEPTH)) begin
          count_reg <= count_reg + CW'(1);
        end
        age_reg      <= '0;
        state_reg    <= HOLD;
        captured_reg <= 1'b1;
        disp_reg     <= bus.rand_in;
      end else if (press_scr && state_reg == LIVE) begin
        if (count_reg != '0) begin
          state_reg <= HOLD;
          age_reg   <= '0;
          disp_reg  <= mem[head_idx];
        end else begin
          disp_reg <= bus.rand_in;
        end
      end else if (press_scr && state_reg == HOLD) begin
        if (can_step_back) begin
          age_reg  <= age_reg + AW'(1);
          disp_reg <= mem[older_idx];
        end else begin
          state_reg <= LIVE;
          age_reg   <= '0;
          disp_reg  <= bus.rand_in;
        end
      end else begin
        disp_reg <= (state_reg == HOLD) ? mem[cur_idx] : bus.rand_in;
      end
    end
  end

  DEC_7SEG u_dec_lo (
    .hex (disp_reg[3:0]),
    .seg (bus.seg_lo)
  );

  DEC_7SEG u_dec_hi (
    .hex (disp_reg[7:4]),
    .seg (bus.seg_hi)
  );

  assign bus.count    = count_reg;
  assign bus.hold     = (state_reg == HOLD);
  assign bus.captured = captured_reg;

endmodule
